// File: rtl/gcd_fifo_reader.sv
// GCD operand consumer: pops A then B from a registered-read FIFO,
// reduces them by repeated subtraction and offers the result on valid/ready.
module gcd_fifo_reader #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  res_ready_i,
    output logic                  res_valid_o,
    output logic [DATA_WIDTH-1:0] res_data_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  res_cnt_o
);

    typedef enum logic [2:0] {
        REQ_A,
        CAP_A,
        REQ_B,
        CAP_B,
        CALC,
        OUT
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  valid_q;
    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    // Pop only from a request state, only when data exists, never in reset.
    assign fifo_rd_en_o = rst_ni && !fifo_empty_i &&
                          ((state_q == REQ_A) || (state_q == REQ_B));

    assign res_valid_o = valid_q;
    assign res_data_o  = res_q;
    assign busy_o      = busy_q;
    assign res_cnt_o   = cnt_q;

    // Pair sequencing, subtraction datapath and result handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= REQ_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                REQ_A: begin
                    if (!fifo_empty_i) begin
                        state_q <= CAP_A;
                        busy_q  <= 1'b1;
                    end
                end
                CAP_A: begin
                    a_q     <= fifo_data_i;
                    state_q <= REQ_B;
                end
                REQ_B: begin
                    if (!fifo_empty_i) begin
                        state_q <= CAP_B;
                    end
                end
                CAP_B: begin
                    b_q     <= fifo_data_i;
                    state_q <= CALC;
                end
                CALC: begin
                    // Zero operands short-circuit; equal operands end the reduction.
                    if (a_q == '0) begin
                        res_q   <= b_q;
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end else if (b_q == '0) begin
                        res_q   <= a_q;
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end else if (a_q == b_q) begin
                        res_q   <= a_q;
                        valid_q <= 1'b1;
                        state_q <= OUT;
                    end else if (a_q > b_q) begin
                        a_q <= a_q - b_q;
                    end else begin
                        b_q <= b_q - a_q;
                    end
                end
                OUT: begin
                    if (valid_q && res_ready_i) begin
                        valid_q <= 1'b0;
                        cnt_q   <= cnt_q + CNT_WIDTH'(1);
                        busy_q  <= 1'b0;
                        state_q <= REQ_A;
                    end
                end
                default: begin
                    state_q <= REQ_A;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gcd_fifo_reader.md
Name: gcd_fifo_reader

Overview:
- Consumer (read side) of the operand FIFO in the GCD datapath.
- Pops operands in pairs (A then B) through the FIFO read port, computes GCD(A,B) by iterative subtraction, and presents the result on a valid/ready output.
- Assumes the FIFO's registered read data: data appears on the FIFO output the cycle after the rd_en edge and holds until the next pop.
- Requires the FIFO empty flag to be brought out as a port.

Parameters:
- DATA_WIDTH, 4, width of each operand and of the result.
- CNT_WIDTH, 8, width of the completed-result counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_rd_en_o  output  1  FIFO pop request.
- fifo_data_i  input  DATA_WIDTH  FIFO registered read data.
- res_ready_i  input  1  downstream accepts result.
- res_valid_o  output  1  result valid.
- res_data_o  output  DATA_WIDTH  GCD result.
- busy_o  output  1  pair in progress (state != REQ_A).
- res_cnt_o  output  CNT_WIDTH  number of accepted results, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async, rst_ni=0):
  - state=REQ_A; internal a and b = 0.
  - res_valid_o=0, res_data_o=0, res_cnt_o=0, busy_o=0.
  - fifo_rd_en_o=0 while in reset.
- FSM states: REQ_A, CAP_A, REQ_B, CAP_B, CALC, OUT. Registers are a and b (DATA_WIDTH each) and res.
- REQ_A:
  - fifo_rd_en_o = !fifo_empty_i (combinational, asserted only in REQ_A/REQ_B).
  - If !fifo_empty_i, go to CAP_A; otherwise stay.
- CAP_A: a <= fifo_data_i; go to REQ_B. fifo_rd_en_o=0.
- REQ_B: same rule as REQ_A; if empty, wait indefinitely with A retained. Then go to CAP_B.
- CAP_B: b <= fifo_data_i; go to CALC.
- CALC, one step per cycle, priority order:
  - a==0 -> res<=b, go OUT
  - else b==0 -> res<=a, go OUT
  - else a==b -> res<=a, go OUT
  - else a>b -> a<=a-b
  - else b<=b-a
  - Subtraction is unsigned and never underflows; gcd(0,0)=0.
- OUT:
  - res_valid_o=1 and res_data_o=res are registered outputs that stay stable while res_valid_o=1.
  - Transfer occurs on the edge where res_valid_o && res_ready_i. At that edge: res_valid_o<=0, res_cnt_o<=res_cnt_o+1, go to REQ_A.
  - res_data_o keeps its last value after the transfer.
- At most one pop per pair slot: never two rd_en in consecutive cycles.
- fifo_rd_en_o is never asserted while fifo_empty_i=1, nor outside REQ_A/REQ_B.
- Latency:
  - CALC takes k+1 cycles, where k is the number of subtractions (1 cycle when either operand is 0).
  - res_valid_o rises 4+(k+1) cycles after the REQ_A cycle with rd_en=1, provided B is available immediately.
- Reset mid-operation: the partial pair is discarded (an already-popped A is lost); the FSM restarts at REQ_A.
- Backpressure: no new pop occurs while in OUT.

Test Plan:
- FIFO holds 12,8, ready=1 -> rd_en pulses in cycles 0 and 2; res_valid_o=1 with res_data_o=4 in cycle 7; res_cnt_o=1 after the transfer.
- Pair 15,1 -> 14 subtractions; res_data_o=1 valid in cycle 19; worst-case 4-bit timing.
- Pairs 0,9 / 9,0 / 0,0 -> results 9, 9, 0, each valid in cycle 5 after its REQ_A.
- FIFO holds only 6; push 9 ten cycles later -> fifo_rd_en_o stays 0 while empty; A=6 retained; result 3.
- res_ready_i=0 for 5 cycles on result 4 -> res_valid_o and res_data_o held; no rd_en pulse; a single count increment after ready.
- Assert rst_ni=0 during CALC of 12,8 -> all outputs 0 asynchronously; after release, the next pair 10,4 gives 2.
